// File: rtl/ads_multich_rx.sv
// ads_multich_rx: serial receiver for a daisy-chained ADC. It synchronises sclk, drdy and dout
// into aclk, deserialises NCH words per frame and delivers them through a 2-entry stream FIFO.
module ads_multich_rx #(
    parameter int DW       = 24,
    parameter int NCH      = 1,
    parameter int SYNC     = 2,
    parameter int DISCARD  = 1,
    parameter int TMO      = 255,
    parameter int START_LO = 16,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          aclk,
    input  logic          areset_n,
    input  logic          en,
    input  logic          sclk,
    input  logic          drdy,
    input  logic          dout,
    output logic          start,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] m_chan,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          overflow,
    output logic          frame_err,
    input  logic          clr_err
);

    localparam int EW = DW + CW + 1;
    localparam logic [15:0] RS_END  = 16'(START_LO > 0 ? START_LO - 1 : 0);
    localparam logic [15:0] TMO_END = 16'(TMO > 0 ? TMO - 1 : 0);

    typedef enum logic [1:0] {IDLE, RESYNC, WAIT, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [SYNC-1:0] sclk_sync_q, sclk_sync_d, drdy_sync_q, drdy_sync_d, dout_sync_q, dout_sync_d;
    logic            sclk_p_q, sclk_p_d, drdy_p_q, drdy_p_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [5:0]      bit_q, bit_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic [7:0]      disc_q, disc_d;
    logic [DW-1:0]   sh_q, sh_d;
    logic            start_q, start_d, wv_q, wv_d, ov_q, ov_d, fe_q, fe_d;
    logic [EW-1:0]   wd_q, wd_d, e0_q, e0_d, e1_q, e1_d;
    logic [1:0]      fcnt_q, fcnt_d;
    logic            sclk_fall, drdy_rise, pop, ov_set, fe_set, last_bit, last_chan;
    logic [DW-1:0]   shifted;
    logic [1:0]      c1;

    assign sclk_fall = sclk_p_q & ~sclk_sync_q[SYNC-1];
    assign drdy_rise = ~drdy_p_q & drdy_sync_q[SYNC-1];
    assign shifted   = {sh_q[DW-2:0], dout_sync_q[SYNC-1]};
    assign last_bit  = bit_q == 6'(DW - 1);
    assign last_chan = chan_q == CW'(NCH - 1);
    assign pop       = (fcnt_q != 2'd0) & m_ready;
    assign c1        = fcnt_q - {1'b0, pop};

    assign {m_data, m_chan, m_last} = e0_q;
    assign m_valid   = fcnt_q != 2'd0;
    assign start     = start_q;
    assign overflow  = ov_q;
    assign frame_err = fe_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC-2:0], sclk};
        drdy_sync_d = {drdy_sync_q[SYNC-2:0], drdy};
        dout_sync_d = {dout_sync_q[SYNC-2:0], dout};
        sclk_p_d    = sclk_sync_q[SYNC-1];
        drdy_p_d    = drdy_sync_q[SYNC-1];
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        chan_d      = chan_q;
        disc_d      = disc_q;
        sh_d        = sh_q;
        start_d     = start_q;
        wv_d        = 1'b0;
        wd_d        = wd_q;
        ov_set      = 1'b0;
        fe_set      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                bit_d   = '0;
                chan_d  = '0;
                disc_d  = '0;
                start_d = 1'b0;
                state_d = en ? RESYNC : IDLE;
            end
            RESYNC: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q >= RS_END) begin
                    state_d = WAIT;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    disc_d  = 8'(DISCARD);
                end
            end
            WAIT: begin
                if (drdy_rise) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                    chan_d  = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (drdy_rise) begin
                    fe_set = 1'b1;
                    bit_d  = '0;
                    chan_d = '0;
                    cnt_d  = '0;
                end else if (sclk_fall) begin
                    sh_d  = shifted;
                    cnt_d = '0;
                    bit_d = last_bit ? 6'd0 : bit_q + 6'd1;
                    if (last_bit) begin
                        chan_d = chan_q + CW'(1);
                        wv_d   = disc_q == 8'd0;
                        wd_d   = {shifted, chan_q, last_chan};
                        if (last_chan) begin
                            state_d = WAIT;
                            disc_d  = (disc_q != 8'd0) ? disc_q - 8'd1 : disc_q;
                        end
                    end
                end else if (cnt_q >= TMO_END) begin
                    fe_set  = 1'b1;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Pop first, then the pending word lands in the first free slot or is dropped.
        e0_d   = pop ? e1_q : e0_q;
        e1_d   = e1_q;
        fcnt_d = c1;
        if (wv_q) begin
            if (c1 == 2'd0) begin
                e0_d   = wd_q;
                fcnt_d = 2'd1;
            end else if (c1 == 2'd1) begin
                e1_d   = wd_q;
                fcnt_d = 2'd2;
            end else begin
                ov_set = 1'b1;
            end
        end
        if (!en) begin
            state_d = IDLE;
            start_d = 1'b0;
            wv_d    = 1'b0;
            fcnt_d  = 2'd0;
            ov_set  = 1'b0;
        end
        ov_d = ov_set | (ov_q & ~clr_err);
        fe_d = fe_set | (fe_q & ~clr_err);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            drdy_sync_q <= '0;
            dout_sync_q <= '0;
            sclk_p_q    <= 1'b0;
            drdy_p_q    <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= '0;
            chan_q      <= '0;
            disc_q      <= '0;
            sh_q        <= '0;
            start_q     <= 1'b0;
            wv_q        <= 1'b0;
            wd_q        <= '0;
            e0_q        <= '0;
            e1_q        <= '0;
            fcnt_q      <= '0;
            ov_q        <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            drdy_sync_q <= drdy_sync_d;
            dout_sync_q <= dout_sync_d;
            sclk_p_q    <= sclk_p_d;
            drdy_p_q    <= drdy_p_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            chan_q      <= chan_d;
            disc_q      <= disc_d;
            sh_q        <= sh_d;
            start_q     <= start_d;
            wv_q        <= wv_d;
            wd_q        <= wd_d;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
            fcnt_q      <= fcnt_d;
            ov_q        <= ov_d;
            fe_q        <= fe_d;
        end
    end

endmodule

// File: tb/tb_ads_multich_rx.sv
// tb_ads_multich_rx: directed bench with a single-channel/discard instance and a
// four-channel no-discard instance sharing the serial lines.
module tb_ads_multich_rx;

    logic aclk = 1'b0, areset_n = 1'b0, sclk = 1'b0, drdy = 1'b0, dout = 1'b0, clr_err = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, rdy_a = 1'b0, rdy_b = 1'b0;
    logic start_a, va, la, ova, fea;
    logic start_b, vb, lb, ovb, feb;
    logic [23:0] da, db;
    logic        ca;
    logic [1:0]  cb;
    logic [25:0] qa[$];
    logic [26:0] qb[$];
    int n_chk = 0, n_pass = 0, n = 0;

    always #5 aclk = ~aclk;

    ads_multich_rx u_a (
        .aclk(aclk), .areset_n(areset_n), .en(en_a), .sclk(sclk), .drdy(drdy), .dout(dout),
        .start(start_a), .m_data(da), .m_chan(ca), .m_valid(va), .m_ready(rdy_a), .m_last(la),
        .overflow(ova), .frame_err(fea), .clr_err(clr_err)
    );

    ads_multich_rx #(.NCH(4), .DISCARD(0)) u_b (
        .aclk(aclk), .areset_n(areset_n), .en(en_b), .sclk(sclk), .drdy(drdy), .dout(dout),
        .start(start_b), .m_data(db), .m_chan(cb), .m_valid(vb), .m_ready(rdy_b), .m_last(lb),
        .overflow(ovb), .frame_err(feb), .clr_err(clr_err)
    );

    always @(negedge aclk) begin
        if (va && rdy_a) qa.push_back({da, ca, la});
        if (vb && rdy_b) qb.push_back({db, cb, lb});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int c);
        repeat (c) tick();
    endtask

    task automatic drdy_pulse();
        drdy = 1'b1;
        idle(4);
        drdy = 1'b0;
        idle(3);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            dout = w[23-i];
            idle(2);
            sclk = 1'b1;
            idle(3);
            sclk = 1'b0;
            idle(3);
        end
    endtask

    task automatic frame(input logic [23:0] w);
        drdy_pulse();
        send_bits(w, 24);
    endtask

    task automatic wait_start(input bit b, output int c);
        c = 0;
        while (((b ? start_b : start_a) == 1'b0) && c < 100) begin
            tick();
            c++;
        end
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
    endtask

    initial begin
        idle(3);
        chk("rst_start", 32'(start_a), 32'd0);
        chk("rst_valid", 32'(va), 32'd0);
        chk("rst_data", 32'(da), 32'd0);
        chk("rst_ovf", 32'(ova), 32'd0);
        chk("rst_ferr", 32'(fea), 32'd0);
        areset_n = 1'b1;
        idle(2);

        rdy_a = 1'b1;
        en_a  = 1'b1;
        wait_start(1'b0, n);
        chk("start_low_a", 32'(n), 32'd17);
        frame(24'h800001);
        idle(20);
        chk("discard_beats", 32'(qa.size()), 32'd0);
        frame(24'h7FFFFF);
        idle(20);
        chk("a_beats", 32'(qa.size()), 32'd1);
        chk("a_beat0", 32'(qa[0]), 32'({24'h7FFFFF, 1'b0, 1'b1}));

        qa.delete();
        rdy_a = 1'b0;
        frame(24'h000111);
        frame(24'h000222);
        frame(24'h000333);
        idle(20);
        chk("ovf_set", 32'(ova), 32'd1);
        chk("ovf_valid", 32'(va), 32'd1);
        chk("ovf_head", 32'(da), 32'h111);
        rdy_a = 1'b1;
        idle(5);
        chk("ovf_beats", 32'(qa.size()), 32'd2);
        chk("ovf_beat0", 32'(qa[0]), 32'({24'h000111, 1'b0, 1'b1}));
        chk("ovf_beat1", 32'(qa[1]), 32'({24'h000222, 1'b0, 1'b1}));
        clear_errors();
        chk("ovf_clr", 32'(ova), 32'd0);

        qa.delete();
        drdy_pulse();
        send_bits(24'hFFFFFF, 10);
        frame(24'h123456);
        idle(20);
        chk("ferr_rerise", 32'(fea), 32'd1);
        chk("ferr_beats", 32'(qa.size()), 32'd1);
        chk("ferr_beat0", 32'(qa[0]), 32'({24'h123456, 1'b0, 1'b1}));
        clear_errors();
        chk("ferr_clr", 32'(fea), 32'd0);

        qa.delete();
        drdy_pulse();
        send_bits(24'hABCDEF, 5);
        idle(300);
        chk("tmo_ferr", 32'(fea), 32'd1);
        chk("tmo_beats", 32'(qa.size()), 32'd0);
        chk("tmo_valid", 32'(va), 32'd0);
        clear_errors();
        frame(24'h0ABCDE);
        idle(20);
        chk("tmo_wait_noerr", 32'(fea), 32'd0);
        chk("tmo_next_beats", 32'(qa.size()), 32'd1);
        chk("tmo_next_beat0", 32'(qa[0]), 32'({24'h0ABCDE, 1'b0, 1'b1}));

        qa.delete();
        rdy_a = 1'b0;
        frame(24'h055555);
        idle(20);
        chk("pre_rst_valid", 32'(va), 32'd1);
        drdy_pulse();
        send_bits(24'hFFFFFF, 6);
        drdy_pulse();
        send_bits(24'hFFFFFF, 4);
        chk("pre_rst_ferr", 32'(fea), 32'd1);
        areset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(va), 32'd0);
        chk("arst_data", 32'(da), 32'd0);
        chk("arst_last", 32'(la), 32'd0);
        chk("arst_start", 32'(start_a), 32'd0);
        chk("arst_ferr", 32'(fea), 32'd0);
        chk("arst_ovf", 32'(ova), 32'd0);
        idle(2);
        areset_n = 1'b1;
        rdy_a    = 1'b1;
        wait_start(1'b0, n);
        chk("start_low_rst", 32'(n), 32'd17);
        frame(24'h111111);
        frame(24'h222222);
        idle(20);
        chk("rst_disc_beats", 32'(qa.size()), 32'd1);
        chk("rst_disc_beat0", 32'(qa[0]), 32'({24'h222222, 1'b0, 1'b1}));

        en_a  = 1'b0;
        en_b  = 1'b1;
        rdy_b = 1'b1;
        wait_start(1'b1, n);
        chk("start_low_b", 32'(n), 32'd17);
        drdy_pulse();
        for (int i = 1; i <= 4; i++) send_bits(24'(i), 24);
        idle(20);
        chk("b_beats", 32'(qb.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b_beat%0d", i), 32'(qb[i]), 32'({24'(i + 1), 2'(i), i == 3}));
        chk("b_ovf", 32'(ovb), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ads_multich_rx.md
ADS_MULTICH_RX -- requirements
Module: ads_multich_rx

Interface
REQ-001 SHALL have parameter DW, default 24, ADC word width in bits (8..32).
REQ-002 SHALL have parameter NCH, default 1, words per frame (daisy-chained channels, 1..8).
REQ-003 SHALL have parameter SYNC, default 2, synchroniser stages on sclk/drdy/dout (>=2).
REQ-004 SHALL have parameter DISCARD, default 1, frames dropped after en rises (lock frame).
REQ-005 SHALL have parameter TMO, default 255, aclk cycles without sclk fall before frame abort.
REQ-006 SHALL have parameter START_LO, default 16, aclk cycles start is held low after en rises.
REQ-007 SHALL have aclk  input  1  sole clock; sclk, drdy and dout are sampled as data.
REQ-008 SHALL have areset_n  input  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have en  input  1  receiver enable.
REQ-010 SHALL have sclk, drdy, dout  input  1 each  ADC serial clock, data-ready, serial data.
REQ-011 SHALL have start  output  1  ADC START pin.
REQ-012 SHALL have m_data  output  DW  signed word, two's complement, MSB first on wire.
REQ-013 SHALL have m_chan  output  CW=max(1,clog2(NCH))  channel index of m_data.
REQ-014 SHALL have m_valid, m_ready  output/input  1  stream handshake; m_last output 1 marks channel NCH-1.
REQ-015 SHALL have overflow, frame_err  output  1 each  sticky error flags; clr_err input 1 clears both.

Function
REQ-016 SHALL pass sclk, drdy, dout through SYNC flops, then one edge-detect flop; edges act on synced signals only.
REQ-017 SHALL implement states IDLE, RESYNC, WAIT, SHIFT.
REQ-018 IDLE: en=0; start=0, counters cleared; en 0->1 -> RESYNC.
REQ-019 RESYNC: start=0 for START_LO cycles, then start=1, discard counter loaded with DISCARD -> WAIT.
REQ-020 WAIT: drdy rising edge -> SHIFT with bit count 0, chan 0.
REQ-021 SHIFT: each sclk falling edge shifts dout into LSB; after DW bits word is complete, chan increments.
REQ-022 After NCH words in SHIFT -> WAIT; if discard counter >0, frame's words not output, counter decrements.
REQ-023 Completed word SHALL reach the output FIFO the cycle after its last-bit edge; m_valid asserts one cycle later.
REQ-024 Output SHALL be a 2-entry FIFO of {data, chan, last}; handshake on m_valid&m_ready; m_data/m_chan/m_last stable while m_valid&!m_ready.
REQ-025 Word completing with FIFO full (no pop that cycle) SHALL be dropped and set overflow; pop and push in same cycle with FIFO full is legal, no drop.
REQ-026 drdy rising edge while in SHIFT SHALL set frame_err, discard partial frame, restart SHIFT at bit 0, chan 0.
REQ-027 TMO cycles in SHIFT with no sclk fall SHALL set frame_err and return to WAIT; partial word discarded.
REQ-028 en=0 in any state SHALL return to IDLE next cycle, flush FIFO, m_valid=0; error flags retained.
REQ-029 clr_err SHALL clear flags next cycle; a simultaneous set event wins over clr_err.
REQ-030 Discarded or aborted frames SHALL never produce m_valid.

Reset
REQ-031 areset_n=0 SHALL immediately force IDLE, start=0, m_valid=0, m_data=0, m_chan=0, m_last=0, overflow=0, frame_err=0, FIFO empty, synchronisers 0.
REQ-032 After areset_n release with en=1, the block SHALL pass through RESYNC exactly as after an en rise.

Verification
REQ-033 DW=24,NCH=1,DISCARD=1: en=1, two frames 0x800001 then 0x7FFFFF, m_ready=1 -> first dropped, one beat m_data=0x7FFFFF, m_chan=0, m_last=1; start low 16 cycles after en.
REQ-034 NCH=4, DISCARD=0: frame words 0x000001..0x000004 -> four beats, m_chan 0..3, m_last only on 3.
REQ-035 m_ready=0, three words received -> first two held in order, third dropped, overflow=1; clr_err -> overflow=0.
REQ-036 drdy re-rise after 10 of 24 bits -> frame_err=1, next complete frame 0x123456 delivered correctly.
REQ-037 sclk stops after 5 bits for 300 cycles (TMO=255) -> frame_err=1, state WAIT, no m_valid.
REQ-038 areset_n pulsed low mid-SHIFT with m_valid=1 -> all outputs 0 asynchronously; after release, RESYNC and DISCARD repeat.
